// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage rv32i pipeline: stage enables/flushes, load-use, redirect, mem wait, halt.
// Optional macro PIPE_CTRL_PERF_EN adds stall/flush/memwait performance counters.
module pipeline_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  dmem_busy,
  input  logic                  id_halt,
  input  logic                  resume,
  output logic                  pc_ena,
  output logic                  ifid_ena,
  output logic                  idex_ena,
  output logic                  exmem_ena,
  output logic                  memwb_ena,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic [2:0]            state_o,
  output logic                  fault
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_memwait_cnt
`endif
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    MEM_WAIT   = 3'd1,
    HALT_DRAIN = 3'd2,
    HALT       = 3'd3,
    FAULT      = 3'd4
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_t           state, state_nx;
  logic [TMO_W-1:0] tmo_cnt, tmo_nx;
  logic [1:0]       drain_cnt, drain_nx;
  logic             fault_q, fault_nx;
  logic             hazard;
  logic             run_like;
  logic             freeze;
  logic             count_busy;

  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign state_o = state;
  assign fault   = fault_q;

  always_comb begin
    pc_ena      = 1'b1;
    ifid_ena    = 1'b1;
    idex_ena    = 1'b1;
    exmem_ena   = 1'b1;
    memwb_ena   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    state_nx    = state;
    tmo_nx      = tmo_cnt;
    drain_nx    = drain_cnt;
    fault_nx    = fault_q;
    run_like    = 1'b0;
    freeze      = 1'b0;
    count_busy  = 1'b0;

    case (state)
      RUN: begin
        if (mem_req && dmem_busy) begin
          freeze   = 1'b1;
          state_nx = MEM_WAIT;
          tmo_nx   = '0;
        end else begin
          run_like = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_busy) begin
          freeze     = 1'b1;
          count_busy = 1'b1;
        end else begin
          run_like = 1'b1;
        end
      end
      HALT_DRAIN: begin
        // A busy memory pauses the drain exactly like MEM_WAIT, without advancing it.
        if (dmem_busy) begin
          freeze     = 1'b1;
          count_busy = 1'b1;
        end else begin
          tmo_nx     = '0;
          pc_ena     = 1'b0;
          ifid_ena   = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = (drain_cnt != 2'd0);
          if (drain_cnt == 2'd2) begin
            state_nx = HALT;
            drain_nx = 2'd0;
          end else begin
            drain_nx = drain_cnt + 2'd1;
          end
        end
      end
      HALT: begin
        {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena} = '0;
        if (resume) state_nx = RUN;
      end
      FAULT: begin
        {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena} = '0;
      end
      default: state_nx = RUN;
    endcase

    if (freeze) begin
      pc_ena      = 1'b0;
      ifid_ena    = 1'b0;
      idex_ena    = 1'b0;
      exmem_ena   = 1'b0;
      memwb_flush = 1'b1;
    end

    if (count_busy) begin
      tmo_nx = tmo_cnt + TMO_W'(1);
      if (tmo_nx >= TMO_LIMIT) begin
        state_nx = FAULT;
        fault_nx = 1'b1;
      end
    end

    // Redirect outranks load-use, and both suppress a halt seen in the same cycle.
    if (run_like) begin
      tmo_nx   = '0;
      state_nx = RUN;
      if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (hazard) begin
        pc_ena     = 1'b0;
        ifid_ena   = 1'b0;
        idex_flush = 1'b1;
      end else if (id_halt) begin
        pc_ena     = 1'b0;
        ifid_ena   = 1'b0;
        ifid_flush = 1'b1;
        state_nx   = HALT_DRAIN;
        drain_nx   = 2'd0;
      end
    end

    if (!rst) begin
      {pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena}     = '0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush}     = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      tmo_cnt   <= '0;
      drain_cnt <= '0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      tmo_cnt   <= tmo_nx;
      drain_cnt <= drain_nx;
      fault_q   <= fault_nx;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic stall_evt;
  logic redirect_evt;

  assign stall_evt    = run_like && !ex_redirect && hazard;
  assign redirect_evt = run_like && ex_redirect;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cnt   <= '0;
      perf_flush_cnt   <= '0;
      perf_memwait_cnt <= '0;
    end else begin
      if (stall_evt)         perf_stall_cnt   <= perf_stall_cnt + 32'd1;
      if (redirect_evt)      perf_flush_cnt   <= perf_flush_cnt + 32'd1;
      if (state == MEM_WAIT) perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized self-checking bench for pipeline_ctrl against a behavioural pipeline-control model.
module tb_pipeline_ctrl;
  localparam int RW  = 5;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic          mem_req, dmem_busy, id_halt, resume;
  logic          pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [2:0]    state_o;
  logic          fault;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt;
`endif

  pipeline_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TMO), .TMO_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_busy(dmem_busy), .id_halt(id_halt), .resume(resume),
    .pc_ena(pc_ena), .ifid_ena(ifid_ena), .idex_ena(idex_ena), .exmem_ena(exmem_ena), .memwb_ena(memwb_ena),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .state_o(state_o), .fault(fault)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_memwait_cnt(perf_memwait_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Model: what the pipeline is doing, not how the controller encodes it.
  bit          m_fault, m_halted, m_waiting;
  int          m_drain_left, m_busy_run;
  logic [31:0] m_stalls, m_flushes, m_waits;

  // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
  localparam logic [8:0] CLEAR   = 9'b00000_1111;
  localparam logic [8:0] FROZEN  = 9'b00001_0001;
  localparam logic [8:0] ALL_RUN = 9'b11111_0000;
  localparam logic [8:0] BRANCH  = 9'b11111_1100;
  localparam logic [8:0] BUBBLE  = 9'b00111_0100;
  localparam logic [8:0] HALTIN  = 9'b00111_1000;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit hazardNow();
    bit hit = 1'b0;
    if (ex_mem_read && ex_rd != 0) begin
      if (id_uses_rs1 && id_rs1 == ex_rd) hit = 1'b1;
      if (id_uses_rs2 && id_rs2 == ex_rd) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic bit memHolds();
    return dmem_busy && (m_drain_left > 0 || m_waiting || mem_req);
  endfunction

  function automatic bit freeRunning();
    return !m_fault && !m_halted && m_drain_left == 0 && !memHolds();
  endfunction

  function automatic logic [8:0] expCtrl();
    if (!rst) return CLEAR;
    if (m_fault || m_halted) return 9'b0;
    if (memHolds()) return FROZEN;
    if (m_drain_left > 0) return {5'b00111, 1'b1, (m_drain_left < 3), 2'b00};
    if (ex_redirect) return BRANCH;
    if (hazardNow()) return BUBBLE;
    if (id_halt) return HALTIN;
    return ALL_RUN;
  endfunction

  function automatic logic [2:0] expState();
    if (m_fault) return 3'd4;
    if (m_halted) return 3'd3;
    if (m_drain_left > 0) return 3'd2;
    if (m_waiting) return 3'd1;
    return 3'd0;
  endfunction

  task automatic busyTick();
    m_busy_run++;
    if (m_busy_run >= TMO) begin
      m_fault = 1'b1;
      m_waiting = 1'b0;
      m_drain_left = 0;
    end
  endtask

  task automatic updateModel();
    if (!rst) begin
      {m_fault, m_halted, m_waiting} = '0;
      m_drain_left = 0;
      m_busy_run = 0;
      m_stalls = 0; m_flushes = 0; m_waits = 0;
      return;
    end
    if (freeRunning() && ex_redirect) m_flushes++;
    if (freeRunning() && !ex_redirect && hazardNow()) m_stalls++;
    if (expState() == 3'd1) m_waits++;
    if (m_fault) begin
    end else if (m_halted) begin
      if (resume) m_halted = 1'b0;
    end else if (m_drain_left > 0) begin
      if (dmem_busy) busyTick();
      else begin
        m_busy_run = 0;
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1'b1;
      end
    end else if (m_waiting && dmem_busy) begin
      busyTick();
    end else if (!m_waiting && mem_req && dmem_busy) begin
      m_waiting = 1'b1;
      m_busy_run = 0;
    end else begin
      m_waiting = 1'b0;
      m_busy_run = 0;
      if (id_halt && !ex_redirect && !hazardNow()) m_drain_left = 3;
    end
  endtask

  // Check the cycle's outputs with current inputs, then clock it into the model.
  task automatic applyStimulus(input string tag);
    #1;
    checkOutput({tag, "_ctrl"}, 32'({pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'(expCtrl()));
    checkOutput({tag, "_state"}, 32'(state_o), 32'(expState()));
    checkOutput({tag, "_fault"}, 32'(fault), 32'(m_fault));
`ifdef PIPE_CTRL_PERF_EN
    checkOutput({tag, "_pstall"}, perf_stall_cnt, m_stalls);
    checkOutput({tag, "_pflush"}, perf_flush_cnt, m_flushes);
    checkOutput({tag, "_pwait"}, perf_memwait_cnt, m_waits);
`endif
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect} = '0;
    {mem_req, dmem_busy, id_halt, resume} = '0;
  endtask

  task automatic randInputs(input int busyStart, input int busyKeep, input int haltPct, input int rstPct);
    rst         = ($urandom_range(99) >= rstPct);
    id_rs1      = RW'($urandom_range(3));
    id_rs2      = RW'($urandom_range(3));
    ex_rd       = RW'($urandom_range(3));
    id_uses_rs1 = $urandom_range(1);
    id_uses_rs2 = $urandom_range(1);
    ex_mem_read = $urandom_range(1);
    ex_redirect = ($urandom_range(99) < 15);
    mem_req     = $urandom_range(1);
    dmem_busy   = dmem_busy ? ($urandom_range(99) < busyKeep) : ($urandom_range(99) < busyStart);
    id_halt     = ($urandom_range(99) < haltPct);
    resume      = ($urandom_range(99) < 25);
  endtask

  initial begin
    clearInputs();
    rst = 1'b0;
    {m_fault, m_halted, m_waiting} = '0;
    m_drain_left = 0; m_busy_run = 0;
    m_stalls = 0; m_flushes = 0; m_waits = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    applyStimulus("reset0");
    applyStimulus("reset1");
    rst = 1'b1;
    applyStimulus("release");

    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    applyStimulus("loaduse");
    clearInputs();
    applyStimulus("after_lu");
    ex_mem_read = 1'b1; id_uses_rs1 = 1'b1;
    applyStimulus("x0_no_stall");
    ex_rd = 5'd7; id_rs1 = 5'd7; ex_redirect = 1'b1;
    applyStimulus("redir_lu");
    clearInputs();

    mem_req = 1'b1; dmem_busy = 1'b1;
    repeat (4) applyStimulus("memwait");
    dmem_busy = 1'b0;
    applyStimulus("memwait_exit");
    clearInputs();
    applyStimulus("after_wait");

    mem_req = 1'b1; dmem_busy = 1'b1;
    repeat (TMO + 1) applyStimulus("timeout");
    resume = 1'b1;
    applyStimulus("fault_resume");
    #1;
    checkOutput("fault_sticky", 32'(fault), 32'd1);
    checkOutput("fault_state", 32'(state_o), 32'd4);
    rst = 1'b0;
    applyStimulus("fault_reset");
    clearInputs();
    applyStimulus("fault_cleared");

    id_halt = 1'b1;
    applyStimulus("halt_in");
    id_halt = 1'b0;
    repeat (4) applyStimulus("halt_drain");
    resume = 1'b1;
    applyStimulus("halt_resume");
    clearInputs();
    applyStimulus("resumed");
    id_halt = 1'b1; ex_redirect = 1'b1;
    applyStimulus("halt_redir");
    clearInputs();
    applyStimulus("halt_redir_run");

    repeat (300) begin randInputs(10, 60, 5, 1);  applyStimulus("rand_mix"); end
    repeat (300) begin randInputs(5, 97, 3, 2);   applyStimulus("rand_long_busy"); end
    repeat (300) begin randInputs(20, 50, 25, 1); applyStimulus("rand_halt"); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
